stepper_move_ctrl: RTL and testbench
====================================

Name: stepper_move_ctrl

Overview:
Motion command stage directly upstream of the stepper coil sequencer. Accepts a move command (direction, step count, cruise period) over a valid/ready handshake. Emits a direction level and single-cycle step pulses with a symmetric linear accel/decel period ramp. dir_out/step_out drive the sequencer's two 1-bit inputs.

Parameters:
STEP_W, 16, width of cmd_steps and internal remaining-step counter
PER_W, 16, width of period values, in system1000 cycles
START_PERIOD, 100, period of first/last step of a move; ramp ceiling
RAMP_DEC, 10, period change per step while ramping
MIN_PERIOD, 2, lower clamp on cruise period; guarantees a low cycle between step pulses
DIR_SETUP, 4, cycles dir_out is stable before the first step of a move

Ports:
system1000  in  1  clock
system1000_rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  controller idle, can accept
cmd_dir  in  1  direction for the move, 1 = forward
cmd_steps  in  STEP_W  number of steps
cmd_period  in  PER_W  cruise period in cycles
abort  in  1  stop current move
dir_out  out  1  direction level to sequencer
step_out  out  1  one-cycle step pulse to sequencer
busy  out  1  high in SETTLE and RUN
done  out  1  one-cycle pulse at move end
aborted  out  1  high with done when the move ended by abort

Behaviour:
- Reset (synchronous, priority over all): state IDLE. All outputs 0 except cmd_ready, which goes to 1 in the first cycle after reset deasserts. Counters cleared. Reset mid-move stops step pulses immediately; no done pulse.
- States:
  - IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready. dir_out<=cmd_dir. rem<=cmd_steps. target<=max(cmd_period,MIN_PERIOD). cur<=max(START_PERIOD,target). ramp<=0. Next state SETTLE.
  - cmd_steps==0 special case: accepted, dir_out unchanged, no pulses. done=1 the next cycle, state stays IDLE.
  - SETTLE: busy=1 for DIR_SETUP cycles (T+1..T+DIR_SETUP, T = accept cycle). Then RUN with timer<=cur-1.
  - RUN: timer decrements each cycle. When timer==0, step_out=1 for that cycle, then:
    - rem'=rem-1.
    - rem'==0: go to IDLE.
    - rem'<=ramp (decel): cur<=min(cur+RAMP_DEC,START_PERIOD); ramp<=ramp-1, saturating at 0.
    - cur>target (accel): cur<=max(cur-RAMP_DEC,target); ramp<=ramp+1.
    - otherwise cruise: cur unchanged.
    - timer<=new cur-1.
- Move end: done=1 in the first IDLE cycle after the final pulse. cmd_ready=1 in that same cycle, so back-to-back accept is allowed.
- Abort in SETTLE or RUN: next cycle IDLE with done=1, aborted=1. Abort wins over a coincident timer==0, so no pulse is emitted that cycle. Abort in IDLE is ignored. Abort coincident with an accept: accept wins.
- cmd_valid during busy: ignored, not latched.
- dir_out holds its value between moves.
- Arithmetic unsigned. Ramp add saturates at START_PERIOD, subtract at target; no wrap. ramp counter is STEP_W wide.

Decomposition:
- Package stepper_pkg: state enum (IDLE, SETTLE, RUN), STEP_W/PER_W defaults, period and step-count typedefs.
- Sub-module step_period_ramp: combinational next-period/next-ramp computation from (cur, target, rem', ramp); unit-testable in isolation.

Test Plan (defaults: START_PERIOD=100, RAMP_DEC=10, DIR_SETUP=4, MIN_PERIOD=2):
- Plain move: accept at T with cmd_steps=3, cmd_period=100, cmd_dir=1 -> dir_out=1 at T+1; pulses at T+104, T+204, T+304; done at T+305; cmd_ready=1 at T+305.
- Ramp: cmd_steps=10, cmd_period=70 -> inter-pulse intervals 100,90,80,70,70,70,70,80,90,100; exactly 10 pulses; aborted=0.
- Abort: cmd_steps=50, cmd_period=100, abort asserted in the cycle of the 3rd pulse's timer==0 -> only 2 pulses; next cycle done=1, aborted=1, busy=0.
- Edge commands: cmd_steps=0 -> no pulse, done one cycle after accept, dir_out unchanged. cmd_period=0, cmd_steps=4, START_PERIOD=2 -> every interval =2, pulses never on adjacent cycles.
- Reset mid-move: reset at pulse 5 of 20 -> step_out, busy, done all 0 from the next edge. New command accepted after release; exactly its count delivered.
- Handshake: cmd_valid held with new values during a move -> ignored. Accepted in the done cycle -> second move starts with DIR_SETUP re-applied and the new direction.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types and defaults for the stepper motion command stage.
package stepper_pkg;

  localparam int STEP_W_DEF = 16;
  localparam int PER_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  typedef logic [PER_W_DEF-1:0]  period_t;
  typedef logic [STEP_W_DEF-1:0] steps_t;

endpackage

// File: rtl/step_period_ramp.sv
// Next step period and ramp depth after a step pulse.
// Decel (remaining steps within the ramp depth) has priority over accel.
// All arithmetic is done one bit wider so add/subtract clamp instead of wrapping.
module step_period_ramp #(
  parameter int STEP_W       = 16,
  parameter int PER_W        = 16,
  parameter int START_PERIOD = 100,
  parameter int RAMP_DEC     = 10
) (
  input  logic [PER_W-1:0]  cur,
  input  logic [PER_W-1:0]  target,
  input  logic [STEP_W-1:0] rem_next,
  input  logic [STEP_W-1:0] ramp,
  output logic [PER_W-1:0]  cur_next,
  output logic [STEP_W-1:0] ramp_next
);

  localparam logic [PER_W:0] START_W = (PER_W+1)'(START_PERIOD);
  localparam logic [PER_W:0] DEC_W   = (PER_W+1)'(RAMP_DEC);

  logic [PER_W:0] cur_w;
  logic [PER_W:0] sum_w;
  logic [PER_W:0] floor_w;

  assign cur_w   = {1'b0, cur};
  assign sum_w   = cur_w + DEC_W;
  assign floor_w = {1'b0, target} + DEC_W;

  // Pick decel, accel or cruise and produce the clamped next period.
  always_comb begin
    cur_next  = cur;
    ramp_next = ramp;
    if (rem_next <= ramp) begin
      cur_next  = (sum_w > START_W) ? START_W[PER_W-1:0] : sum_w[PER_W-1:0];
      ramp_next = (ramp == '0) ? '0 : ramp - STEP_W'(1);
    end else if (cur > target) begin
      cur_next  = (cur_w < floor_w) ? target : cur - DEC_W[PER_W-1:0];
      ramp_next = ramp + STEP_W'(1);
    end
  end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Move command stage: accepts a move, holds direction for a settle time,
// then issues step pulses with a linear accel/decel period ramp.
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int STEP_W       = STEP_W_DEF,
  parameter int PER_W        = PER_W_DEF,
  parameter int START_PERIOD = 100,
  parameter int RAMP_DEC     = 10,
  parameter int MIN_PERIOD   = 2,
  parameter int DIR_SETUP    = 4
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [PER_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              dir_out,
  output logic              step_out,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int SET_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);

  state_t            state_reg, state_next;
  logic              dir_reg;
  logic [STEP_W-1:0] rem_reg;
  logic [STEP_W-1:0] ramp_reg;
  logic [PER_W-1:0]  target_reg;
  logic [PER_W-1:0]  cur_reg;
  logic [PER_W-1:0]  timer_reg;
  logic [SET_W-1:0]  settle_reg;
  logic              done_reg;
  logic              aborted_reg;

  logic              steps_zero;
  logic              tick;
  logic              last;
  logic [PER_W-1:0]  target_in;
  logic [PER_W-1:0]  cur_in;
  logic [STEP_W-1:0] rem_dec;
  logic [PER_W-1:0]  cur_next;
  logic [STEP_W-1:0] ramp_next;

  assign steps_zero = (cmd_steps == '0);
  assign tick       = (state_reg == RUN) && (timer_reg == '0);
  assign last       = (rem_reg == STEP_W'(1));
  assign target_in  = (cmd_period < MIN_P) ? MIN_P : cmd_period;
  assign cur_in     = (target_in > START_P) ? target_in : START_P;
  assign rem_dec    = rem_reg - STEP_W'(1);

  step_period_ramp #(
    .STEP_W       (STEP_W),
    .PER_W        (PER_W),
    .START_PERIOD (START_PERIOD),
    .RAMP_DEC     (RAMP_DEC)
  ) u_ramp (
    .cur       (cur_reg),
    .target    (target_reg),
    .rem_next  (rem_dec),
    .ramp      (ramp_reg),
    .cur_next  (cur_next),
    .ramp_next (ramp_next)
  );

  // State register.
  always_ff @(posedge system1000) begin
    if (system1000_rst) state_reg <= IDLE;
    else                state_reg <= state_next;
  end

  // Next-state: abort ends a move, the final pulse returns to idle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid && !steps_zero) state_next = SETTLE;
      SETTLE:  if (abort) state_next = IDLE;
               else if (settle_reg == '0) state_next = RUN;
      RUN:     if (abort) state_next = IDLE;
               else if (tick && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs; reset forces everything low in the same cycle.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    step_out  = 1'b0;
    dir_out   = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;
    if (!system1000_rst) begin
      cmd_ready = (state_reg == IDLE);
      busy      = (state_reg != IDLE);
      step_out  = tick && !abort;
      dir_out   = dir_reg;
      done      = done_reg;
      aborted   = aborted_reg;
    end
  end

  // Command latch, settle counter, step timer and ramp bookkeeping.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      dir_reg     <= 1'b0;
      rem_reg     <= '0;
      ramp_reg    <= '0;
      target_reg  <= '0;
      cur_reg     <= '0;
      timer_reg   <= '0;
      settle_reg  <= '0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            if (steps_zero) begin
              done_reg <= 1'b1;
            end else begin
              dir_reg    <= cmd_dir;
              rem_reg    <= cmd_steps;
              target_reg <= target_in;
              cur_reg    <= cur_in;
              ramp_reg   <= '0;
              settle_reg <= SET_W'(DIR_SETUP - 1);
            end
          end
        end
        SETTLE: begin
          if (abort) begin
            done_reg    <= 1'b1;
            aborted_reg <= 1'b1;
          end else if (settle_reg == '0) begin
            timer_reg <= cur_reg - PER_W'(1);
          end else begin
            settle_reg <= settle_reg - SET_W'(1);
          end
        end
        RUN: begin
          if (abort) begin
            done_reg    <= 1'b1;
            aborted_reg <= 1'b1;
          end else if (timer_reg == '0) begin
            rem_reg <= rem_dec;
            if (last) begin
              done_reg <= 1'b1;
            end else begin
              cur_reg   <= cur_next;
              ramp_reg  <= ramp_next;
              timer_reg <= cur_next - PER_W'(1);
            end
          end else begin
            timer_reg <= timer_reg - PER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Self-checking bench for stepper_move_ctrl: table of moves, random moves
// against a timeline model, and hand-written abort/reset/handshake sequences.
module tb_stepper_move_ctrl;

  localparam int DIR_SETUP = 4;
  localparam int MIN_P     = 2;
  localparam int DEC       = 10;

  logic        system1000 = 1'b0;
  logic        system1000_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        cmd_ready, dir_out, step_out, busy, done, aborted;

  logic        c2_valid = 1'b0;
  logic        c2_dir = 1'b0;
  logic [15:0] c2_steps = '0;
  logic [15:0] c2_period = '0;
  logic        c2_ready, c2_dir_out, c2_step, c2_busy, c2_done, c2_aborted;

  stepper_move_ctrl dut (
    .system1000(system1000), .system1000_rst(system1000_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .dir_out(dir_out), .step_out(step_out), .busy(busy), .done(done),
    .aborted(aborted)
  );

  stepper_move_ctrl #(.START_PERIOD(2)) dut2 (
    .system1000(system1000), .system1000_rst(system1000_rst),
    .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_dir(c2_dir),
    .cmd_steps(c2_steps), .cmd_period(c2_period), .abort(1'b0),
    .dir_out(c2_dir_out), .step_out(c2_step), .busy(c2_busy), .done(c2_done),
    .aborted(c2_aborted)
  );

  always #5 system1000 = ~system1000;

  int cyc = 0;
  always @(posedge system1000) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  int   got_q[$];
  int   exp_q[$];
  int   got_done, exp_done;
  logic got_ab;
  int   t_acc;
  logic model_dir = 1'b0;

  typedef struct {
    logic d;
    int   s;
    int   p;
    int   n_exp;
    int   done_exp;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Timeline of one move: pulse offsets from the accept cycle and done offset.
  task automatic model_move(input int s, input int p, input int start);
    int tgt, cur, ramp, rem, t;
    exp_q.delete();
    tgt  = (p < MIN_P) ? MIN_P : p;
    cur  = (start > tgt) ? start : tgt;
    ramp = 0;
    rem  = s;
    t    = DIR_SETUP;
    if (s == 0) begin
      exp_done = 1;
      return;
    end
    while (rem > 0) begin
      t += cur;
      exp_q.push_back(t);
      rem--;
      if (rem == 0) break;
      if (rem <= ramp) begin
        cur = (cur + DEC > start) ? start : cur + DEC;
        if (ramp > 0) ramp--;
      end else if (cur > tgt) begin
        cur = (cur - DEC < tgt) ? tgt : cur - DEC;
        ramp++;
      end
    end
    exp_done = t + 1;
  endtask

  task automatic accept(input logic d, input int s, input int p);
    for (int n = 0; n < 1000 && !cmd_ready; n++) @(negedge system1000);
    chk("cmd_ready_before_accept", cmd_ready, 1);
    cmd_dir    = d;
    cmd_steps  = 16'(s);
    cmd_period = 16'(p);
    cmd_valid  = 1'b1;
    t_acc      = cyc;
    @(negedge system1000);
    cmd_valid = 1'b0;
    if (s != 0) model_dir = d;
  endtask

  // Called at the negedge of accept+1; gathers pulses until done.
  task automatic collect(input bit junk);
    bit seen;
    seen = 0;
    got_q.delete();
    got_done = -1;
    got_ab = 1'b0;
    chk("dir_out_after_accept", dir_out, model_dir);
    for (int n = 0; n < 20000 && !seen; n++) begin
      if (n > 0) @(negedge system1000);
      if (step_out) got_q.push_back(cyc - t_acc);
      if (done) begin
        seen = 1;
        got_done = cyc - t_acc;
        got_ab = aborted;
      end
      if (junk && busy) begin
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_dir    = 1'($urandom_range(0, 1));
        cmd_steps  = 16'($urandom_range(0, 9));
        cmd_period = 16'($urandom_range(0, 200));
      end else begin
        cmd_valid = 1'b0;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic verify(input string nm, input int s, input int p, input int start);
    model_move(s, p, start);
    chk({nm, " pulse_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s pulse%0d_at", nm, i), got_q[i], exp_q[i]);
    chk({nm, " done_at"}, got_done, exp_done);
    chk({nm, " aborted"}, got_ab, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, a_done;
    logic prev;
    bit seen;

    tbl[0] = '{1'b1,  3, 100,  3,  305};
    tbl[1] = '{1'b0, 10,  70, 10,  825};
    tbl[2] = '{1'b1,  0,  55,  0,    1};
    tbl[3] = '{1'b1,  4,  70,  4,  365};
    tbl[4] = '{1'b0,  2,  10,  2,  195};
    tbl[5] = '{1'b1,  5, 300,  5, 1505};
    tbl[6] = '{1'b0,  1,   0,  1,  105};

    // Reset state.
    repeat (3) @(negedge system1000);
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst step_out", step_out, 0);
    chk("rst done", done, 0);
    chk("rst dir_out", dir_out, 0);
    @(posedge system1000); #1 system1000_rst = 1'b0;
    @(negedge system1000);
    chk("post_rst cmd_ready", cmd_ready, 1);
    chk("post_rst busy", busy, 0);
    chk("post_rst aborted", aborted, 0);

    // Table of moves.
    for (int i = 0; i < 7; i++) begin
      accept(tbl[i].d, tbl[i].s, tbl[i].p);
      collect(bit'(i % 2));
      chk($sformatf("tbl%0d count", i), got_q.size(), tbl[i].n_exp);
      chk($sformatf("tbl%0d done_off", i), got_done, tbl[i].done_exp);
      verify($sformatf("tbl%0d", i), tbl[i].s, tbl[i].p, 100);
      $display("move tbl%0d dir=%0d steps=%0d period=%0d pulses=%0d done_at=%0d",
               i, tbl[i].d, tbl[i].s, tbl[i].p, got_q.size(), got_done);
    end

    // Abort on the cycle the third pulse would fire.
    accept(1'b1, 50, 100);
    cnt = 0;
    for (int n = 0; n < 3000 && cyc < t_acc + 303; n++) begin
      if (step_out) cnt++;
      @(negedge system1000);
    end
    if (step_out) cnt++;
    @(posedge system1000); #1 abort = 1'b1;
    @(negedge system1000);
    chk("abort no_step", step_out, 0);
    @(posedge system1000); #1 abort = 1'b0;
    @(negedge system1000);
    chk("abort pulses", cnt, 2);
    chk("abort done", done, 1);
    chk("abort aborted", aborted, 1);
    chk("abort busy", busy, 0);
    $display("move abort pulses=%0d done=%0d aborted=%0d", cnt, done, aborted);

    // Abort while idle is ignored.
    @(posedge system1000); #1 abort = 1'b1;
    @(negedge system1000);
    chk("idle_abort ready", cmd_ready, 1);
    @(posedge system1000); #1 abort = 1'b0;
    @(negedge system1000);
    chk("idle_abort done", done, 0);

    // Abort coincident with accept: the accept wins.
    abort = 1'b1;
    accept(1'b1, 2, 100);
    abort = 1'b0;
    chk("abort_accept busy", busy, 1);
    collect(0);
    verify("abort_accept", 2, 100, 100);
    $display("move abort_accept pulses=%0d done_at=%0d", got_q.size(), got_done);

    // Back-to-back accept in the done cycle with a new direction.
    accept(1'b1, 3, 40);
    collect(1);
    verify("b2b_a", 3, 40, 100);
    a_done = t_acc + got_done;
    accept(1'b0, 2, 100);
    chk("b2b accept_cycle", t_acc, a_done);
    collect(0);
    verify("b2b_b", 2, 100, 100);
    $display("move b2b second_accept=%0d pulses=%0d", t_acc, got_q.size());

    // Reset in the cycle of the fifth pulse of a twenty-step move.
    accept(1'b1, 20, 100);
    cnt = 0;
    for (int n = 0; n < 3000 && cnt < 5; n++) begin
      if (n > 0) @(negedge system1000);
      if (step_out) cnt++;
    end
    chk("rst_mid pulse5_at", cyc - t_acc, 504);
    system1000_rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge system1000);
      chk("rst_mid step_out", step_out, 0);
      chk("rst_mid busy", busy, 0);
      chk("rst_mid done", done, 0);
    end
    @(posedge system1000); #1 system1000_rst = 1'b0;
    model_dir = 1'b0;
    @(negedge system1000);
    chk("rst_mid ready", cmd_ready, 1);
    chk("rst_mid done_after", done, 0);
    accept(1'b0, 3, 20);
    collect(0);
    verify("rst_mid_new", 3, 20, 100);
    $display("move rst_mid new pulses=%0d done_at=%0d", got_q.size(), got_done);

    // Short start period: interval 2, pulses never adjacent.
    @(negedge system1000);
    chk("d2 ready", c2_ready, 1);
    c2_dir = 1'b1; c2_steps = 16'd4; c2_period = 16'd0; c2_valid = 1'b1;
    t_acc = cyc;
    @(negedge system1000);
    c2_valid = 1'b0;
    got_q.delete(); got_done = -1; got_ab = 1'b0; prev = 1'b0; seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (n > 0) @(negedge system1000);
      if (c2_step) begin
        chk("d2 adjacent_pulse", prev, 0);
        got_q.push_back(cyc - t_acc);
      end
      prev = c2_step;
      if (c2_done) begin
        seen = 1;
        got_done = cyc - t_acc;
        got_ab = c2_aborted;
      end
    end
    if (!seen) chk("d2 done_timeout", 0, 1);
    verify("d2", 4, 0, 2);
    chk("d2 dir_out", c2_dir_out, 1);
    $display("move d2 pulses=%0d done_at=%0d", got_q.size(), got_done);

    // Random moves with junk commands offered while busy.
    for (int i = 0; i < 8; i++) begin
      int s, p;
      logic d;
      s = $urandom_range(0, 12);
      p = $urandom_range(0, 160);
      d = 1'($urandom_range(0, 1));
      accept(d, s, p);
      collect(1);
      verify($sformatf("rnd%0d", i), s, p, 100);
      $display("move rnd%0d dir=%0d steps=%0d period=%0d pulses=%0d done_at=%0d",
               i, d, s, p, got_q.size(), got_done);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
